// File: rtl/iso_rx_core_gen_if.sv
// Serial line, NACK drive and receive-FIFO read port of iso_rx_core_gen.
// master = receive core side, slave = pad/host side.
interface iso_rx_core_gen_if #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
);
  logic                     serialIn;
  logic                     nackOut;
  logic [DATA_WIDTH-1:0]    dataOut;
  logic                     dataValid;
  logic                     dataRead;
  logic [FIFO_DEPTH_LOG2:0] fifoCount;

  modport master (input serialIn, dataRead, output nackOut, dataOut, dataValid, fifoCount);
  modport slave  (output serialIn, dataRead, input nackOut, dataOut, dataValid, fifoCount);
endinterface

// File: rtl/iso_rx_core_gen.sv
// ISO7816/UART receive core: configurable framing, 3-sample majority vote,
// ISO7816 error-signal generation on parity error and a small receive FIFO.
module iso_rx_core_gen #(
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned CLOCK_PER_BIT_WIDTH = 13,
  parameter int unsigned FIFO_DEPTH_LOG2     = 2,
  parameter logic        START_BIT           = 1'b0
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           rxEnable,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic [3:0]                     dataBits,
  input  logic [1:0]                     parityMode,
  input  logic                           stopBit2,
  input  logic                           msbFirst,
  input  logic                           nackEnable,
  iso_rx_core_gen_if.master              rxIf,
  output logic                           overrunErrorFlag,
  output logic                           frameErrorFlag,
  output logic                           parityErrorFlag,
  input  logic                           ackFlags,
  output logic                           startBit,
  output logic                           run,
  output logic                           endOfRx
);
  localparam int unsigned CW    = CLOCK_PER_BIT_WIDTH;
  localparam int unsigned PW    = FIFO_DEPTH_LOG2;
  localparam int unsigned NW    = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic        IDLE_LVL = ~START_BIT;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, NACK} stateT;

  stateT                 state;
  logic [CW-1:0]         cnt, cpbQ, half;
  logic [3:0]            bitsQ, bitIdx, bitPos, bitsEff;
  logic                  parEnQ, parOddQ, stop2Q, msbQ, nackEnQ;
  logic                  armed, s0, s1, vote, isVote, isWrap;
  logic                  parAcc, parErr;
  logic [DATA_WIDTH-1:0] rxData;
  logic                  pushC, popC, acceptC, overrunSetC, frameSetC, paritySetC;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wrPtr, rdPtr, rdNext;
  logic [NW-1:0]         count, countNext;
  logic [DATA_WIDTH-1:0] headNext;

  // Bit timing, vote and FIFO/flag request decode
  always_comb begin
    half     = cpbQ >> 1;
    vote     = (s0 & s1) | (s0 & rxIf.serialIn) | (s1 & rxIf.serialIn);
    isVote   = (cnt == half + CW'(1));
    isWrap   = (cnt == cpbQ - CW'(1));
    bitPos   = msbQ ? (bitsQ - 4'd1 - bitIdx) : bitIdx;
    bitsEff  = ((dataBits < 4'd5) || (32'(dataBits) > DATA_WIDTH)) ? 4'(DATA_WIDTH) : dataBits;
    pushC    = rxEnable && isVote && (state == STOP1) && !(parErr && nackEnQ);
    frameSetC  = rxEnable && isVote && (vote != IDLE_LVL) &&
                 (((state == STOP1) && !(parErr && nackEnQ)) || (state == STOP2));
    paritySetC = rxEnable && isVote && (state == STOP1) && parErr;
    popC     = rxIf.dataRead && (count != '0);
    acceptC  = pushC && ((count != NW'(DEPTH)) || popC);
    overrunSetC = pushC && (count == NW'(DEPTH)) && !popC;
    rdNext   = popC ? rdPtr + PW'(1) : rdPtr;
    countNext = count;
    if (acceptC && !popC) countNext = count + NW'(1);
    else if (!acceptC && popC) countNext = count - NW'(1);
    if (countNext == '0) headNext = '0;
    else if (acceptC && (wrPtr == rdNext)) headNext = rxData;
    else headNext = mem[rdNext];
  end

  // Character framing state machine
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;  cnt <= '0;  cpbQ <= '0;  bitsQ <= '0;  bitIdx <= '0;
      parEnQ <= 1'b0; parOddQ <= 1'b0; stop2Q <= 1'b0; msbQ <= 1'b0; nackEnQ <= 1'b0;
      armed <= 1'b0;  s0 <= 1'b0;  s1 <= 1'b0;  parAcc <= 1'b0;  parErr <= 1'b0;
      rxData <= '0;   rxIf.nackOut <= 1'b0;
      startBit <= 1'b0; run <= 1'b0; endOfRx <= 1'b0;
    end else if (!rxEnable) begin
      state <= IDLE;  cnt <= '0;  armed <= 1'b0;  rxIf.nackOut <= 1'b0;
      startBit <= 1'b0; run <= 1'b0; endOfRx <= 1'b0;
    end else begin
      endOfRx <= 1'b0;
      cnt <= isWrap ? '0 : cnt + CW'(1);
      if (cnt == half - CW'(1)) s0 <= rxIf.serialIn;
      if (cnt == half) s1 <= rxIf.serialIn;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rxIf.serialIn == IDLE_LVL) armed <= 1'b1;
          else if (armed) begin
            state <= START;  armed <= 1'b0;  startBit <= 1'b1;
            cpbQ <= clocksPerBit;  bitsQ <= bitsEff;  stop2Q <= stopBit2;
            msbQ <= msbFirst;  nackEnQ <= nackEnable;
            parEnQ <= (parityMode == 2'd1) || (parityMode == 2'd2);
            parOddQ <= (parityMode == 2'd1);
            rxData <= '0;  bitIdx <= '0;  parAcc <= 1'b0;  parErr <= 1'b0;
          end
        end
        START: begin
          if (isVote) begin
            if (vote != START_BIT) begin
              state <= IDLE;  startBit <= 1'b0;
            end else run <= 1'b1;
          end else if (isWrap) begin
            state <= DATA;  startBit <= 1'b0;
          end
        end
        DATA: begin
          if (isVote) begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++)
              if (bitPos == 4'(i)) rxData[i] <= vote;
            parAcc <= parAcc ^ vote;
          end
          if (isWrap) begin
            bitIdx <= bitIdx + 4'd1;
            if (bitIdx == bitsQ - 4'd1) state <= parEnQ ? PARITY : STOP1;
          end
        end
        PARITY: begin
          // Total ones even is the odd-mode error, odd is the even-mode error
          if (isVote) parErr <= parAcc ^ vote ^ parOddQ;
          if (isWrap) state <= STOP1;
        end
        STOP1: begin
          if (isVote && parErr && nackEnQ) begin
            state <= NACK;  rxIf.nackOut <= 1'b1;
          end else if (isWrap) begin
            if (stop2Q) state <= STOP2;
            else begin
              state <= IDLE;  run <= 1'b0;  endOfRx <= 1'b1;
            end
          end
        end
        STOP2: begin
          if (isWrap) begin
            state <= IDLE;  run <= 1'b0;  endOfRx <= 1'b1;
          end
        end
        NACK: begin
          // Released at the next vote phase: exactly one etu of error signal
          if (isVote) begin
            state <= IDLE;  rxIf.nackOut <= 1'b0;  run <= 1'b0;  endOfRx <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acceptC) mem[wrPtr] <= rxData;
  end

  // FIFO pointers, registered head view and sticky error flags
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;  rdPtr <= '0;  count <= '0;
      rxIf.dataOut <= '0;  rxIf.dataValid <= 1'b0;  rxIf.fifoCount <= '0;
      overrunErrorFlag <= 1'b0;  frameErrorFlag <= 1'b0;  parityErrorFlag <= 1'b0;
    end else begin
      if (acceptC) wrPtr <= wrPtr + PW'(1);
      rdPtr <= rdNext;
      count <= countNext;
      rxIf.dataOut   <= headNext;
      rxIf.dataValid <= (countNext != '0);
      rxIf.fifoCount <= countNext;
      overrunErrorFlag <= overrunSetC | (overrunErrorFlag & ~ackFlags);
      frameErrorFlag   <= frameSetC   | (frameErrorFlag   & ~ackFlags);
      parityErrorFlag  <= paritySetC  | (parityErrorFlag  & ~ackFlags);
    end
  end
endmodule

// File: tb/tb_iso_rx_core_gen.sv
// Directed bench for iso_rx_core_gen: serial frames in, expected characters
// queued per frame and compared as they are popped from the FIFO.
module tb_iso_rx_core_gen;
  localparam int unsigned DW   = 8;
  localparam int unsigned CPBW = 13;
  localparam int unsigned FL2  = 2;
  localparam int          CPB  = 16;

  logic            clk = 1'b0;
  logic            nReset, rxEnable, stopBit2, msbFirst, nackEnable, ackFlags, txLine;
  logic [CPBW-1:0] clocksPerBit;
  logic [3:0]      dataBits;
  logic [1:0]      parityMode;
  logic            overrunErrorFlag, frameErrorFlag, parityErrorFlag, startBit, run, endOfRx;
  int              nChecks = 0, nFails = 0;
  int              runCyc = 0, eorCyc = 0, startCyc = 0, nackCyc = 0;
  int              r0, e0, st0, n0;
  logic [7:0]      expQ[$];

  iso_rx_core_gen_if #(.DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(FL2)) rxIf ();
  // Pad model: the error signal pulls the open-drain line to the start level
  assign rxIf.serialIn = txLine & ~rxIf.nackOut;

  iso_rx_core_gen #(
    .DATA_WIDTH(DW), .CLOCK_PER_BIT_WIDTH(CPBW), .FIFO_DEPTH_LOG2(FL2), .START_BIT(1'b0)
  ) dut (
    .clk(clk), .nReset(nReset), .rxEnable(rxEnable), .clocksPerBit(clocksPerBit),
    .dataBits(dataBits), .parityMode(parityMode), .stopBit2(stopBit2), .msbFirst(msbFirst),
    .nackEnable(nackEnable), .rxIf(rxIf), .overrunErrorFlag(overrunErrorFlag),
    .frameErrorFlag(frameErrorFlag), .parityErrorFlag(parityErrorFlag), .ackFlags(ackFlags),
    .startBit(startBit), .run(run), .endOfRx(endOfRx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (run) runCyc++;
    if (endOfRx) eorCyc++;
    if (startBit) startCyc++;
    if (rxIf.nackOut) nackCyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      txLine = 1'b1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    check(tag, {13'd0, rxIf.dataOut, rxIf.dataValid, rxIf.fifoCount, overrunErrorFlag,
                frameErrorFlag, parityErrorFlag, rxIf.nackOut, startBit, run, endOfRx}, 32'd0);
  endtask

  // Build start/data/parity/stop frame and shift it out at CPB clocks per bit
  task automatic sendChar(input logic [8:0] d, input int nb, input bit msb, input int par,
                          input bit badPar, input bit two, input logic stop2v,
                          input int spikeBit, input int spikeCyc, input int probeBit);
    logic [15:0] f, t;
    logic [8:0]  sh;
    logic        p;
    int          n;
    f = '0; n = 1; p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      sh = d >> (msb ? (nb - 1 - i) : i);
      f = f | (16'(sh[0]) << n);
      p = p ^ sh[0];
      n++;
    end
    if (par == 1 || par == 2) begin
      f = f | (16'(((par == 1) ? ~p : p) ^ badPar) << n);
      n++;
    end
    f = f | (16'(1) << n);
    n++;
    if (two) begin
      f = f | (16'(stop2v) << n);
      n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < CPB; j++) begin
        @(posedge clk); #1;
        t = f >> b;
        txLine = t[0] ^ ((b == spikeBit) && (j == spikeCyc));
        if (b == probeBit && j == 10) check("nackBeforeCnt10", 32'(rxIf.nackOut), 32'd0);
        if (b == probeBit && j == 11) check("nackAtCnt10", 32'(rxIf.nackOut), 32'd1);
      end
    end
    @(posedge clk); #1;
    txLine = 1'b1;
  endtask

  task automatic readHead(input string tag);
    logic [7:0] exp;
    check({tag, " valid"}, 32'(rxIf.dataValid), 32'd1);
    if (expQ.size() == 0) begin
      nChecks++;
      nFails++;
      $display("FAIL %s: scoreboard empty, observed 0x%0h", tag, rxIf.dataOut);
    end else begin
      exp = expQ.pop_front();
      check(tag, 32'(rxIf.dataOut), 32'(exp));
    end
    rxIf.dataRead = 1'b1;
    @(posedge clk); #1;
    rxIf.dataRead = 1'b0;
  endtask

  initial begin
    nReset = 1'b0; rxEnable = 1'b1; clocksPerBit = CPBW'(CPB); dataBits = 4'd8;
    parityMode = 2'd2; stopBit2 = 1'b0; msbFirst = 1'b0; nackEnable = 1'b0;
    ackFlags = 1'b0; txLine = 1'b1; rxIf.dataRead = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("resetOutputs");
    nReset = 1'b1;
    idle(5);

    // Even parity 0x3B, one stop bit
    r0 = runCyc; e0 = eorCyc;
    sendChar(9'h03B, 8, 1'b0, 2, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    expQ.push_back(8'h3B);
    idle(4);
    check("t1 fifoCount", 32'(rxIf.fifoCount), 32'd1);
    check("t1 flags", {29'd0, overrunErrorFlag, frameErrorFlag, parityErrorFlag}, 32'd0);
    check("t1 endOfRx pulses", 32'(eorCyc - e0), 32'd1);
    check("t1 run cycles", 32'(runCyc - r0), 32'd166);
    readHead("t1 dataOut");
    check("t1 empty after pop", 32'(rxIf.dataValid), 32'd0);

    // 5-cycle start glitch must be rejected at the start vote
    r0 = runCyc; e0 = eorCyc; st0 = startCyc;
    repeat (5) begin
      @(posedge clk); #1;
      txLine = 1'b0;
    end
    idle(30);
    check("glitch startBit cycles", 32'(startCyc - st0), 32'd10);
    check("glitch run", 32'(runCyc - r0), 32'd0);
    check("glitch endOfRx", 32'(eorCyc - e0), 32'd0);
    check("glitch fifoCount", 32'(rxIf.fifoCount), 32'd0);

    // Single-cycle spike at cnt 8 of data bit 0 is outvoted
    sendChar(9'h03A, 8, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1, 9, -1);
    expQ.push_back(8'h3A);
    idle(4);
    check("spike flags", {29'd0, overrunErrorFlag, frameErrorFlag, parityErrorFlag}, 32'd0);
    readHead("spike dataOut");

    // Bad parity with error signalling: NACK one etu, character discarded
    nackEnable = 1'b1;
    e0 = eorCyc; n0 = nackCyc;
    sendChar(9'h03B, 8, 1'b0, 2, 1'b1, 1'b0, 1'b1, -1, 0, 10);
    idle(20);
    check("nack cycles", 32'(nackCyc - n0), 32'd16);
    check("nack parityErrorFlag", 32'(parityErrorFlag), 32'd1);
    check("nack frameErrorFlag", 32'(frameErrorFlag), 32'd0);
    check("nack fifoCount", 32'(rxIf.fifoCount), 32'd0);
    check("nack endOfRx", 32'(eorCyc - e0), 32'd1);
    ackFlags = 1'b1;
    @(posedge clk); #1;
    ackFlags = 1'b0;
    check("ack parityErrorFlag", 32'(parityErrorFlag), 32'd0);
    nackEnable = 1'b0;

    // Five characters into a four-deep FIFO: last one overruns
    for (int i = 1; i <= 5; i++) begin
      sendChar(9'(i), 8, 1'b0, 2, 1'b0, 1'b0, 1'b1, -1, 0, -1);
      if (i <= 4) expQ.push_back(8'(i));
      idle(4);
    end
    check("ovr fifoCount", 32'(rxIf.fifoCount), 32'd4);
    check("ovr overrunErrorFlag", 32'(overrunErrorFlag), 32'd1);
    for (int i = 1; i <= 4; i++) readHead("ovr pop");
    check("ovr dataValid", 32'(rxIf.dataValid), 32'd0);
    rxIf.dataRead = 1'b1;
    @(posedge clk); #1;
    rxIf.dataRead = 1'b0;
    check("empty pop ignored", 32'(rxIf.fifoCount), 32'd0);
    ackFlags = 1'b1;
    @(posedge clk); #1;
    ackFlags = 1'b0;
    check("ack overrunErrorFlag", 32'(overrunErrorFlag), 32'd0);

    // 7 bits MSB-first, no parity, second stop bit low: frame error but stored
    dataBits = 4'd7; msbFirst = 1'b1; stopBit2 = 1'b1; parityMode = 2'd0;
    sendChar(9'h04D, 7, 1'b1, 0, 1'b0, 1'b1, 1'b0, -1, 0, -1);
    expQ.push_back(8'h4D);
    idle(4);
    check("stop2 frameErrorFlag", 32'(frameErrorFlag), 32'd1);
    check("stop2 parityErrorFlag", 32'(parityErrorFlag), 32'd0);
    check("stop2 fifoCount", 32'(rxIf.fifoCount), 32'd1);
    check("stop2 dataOut msb", 32'(rxIf.dataOut[7]), 32'd0);
    check("stop2 dataOut", 32'(rxIf.dataOut), 32'h4D);

    // Asynchronous reset in the middle of the next character
    repeat (40) begin
      @(posedge clk); #1;
      txLine = 1'b0;
    end
    check("mid-char run", 32'(run), 32'd1);
    nReset = 1'b0;
    #1;
    checkAllZero("midCharReset");
    expQ.delete();
    txLine = 1'b1;
    @(posedge clk); #1;
    nReset = 1'b1;
    idle(3);
    checkAllZero("afterReset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
